// File: rtl/pad_ai_ctrl.sv
// Computer-controlled Pong paddle: tracks the approaching ball one column per move tick
// and returns home while the ball recedes. Optional miss jitter via macro PAD_AI_JITTER_EN.
module pad_ai_ctrl #(
    parameter int unsigned COLS     = 8,
    parameter int unsigned XW       = 3,
    parameter int unsigned PAD_HALF = 1,
    parameter int unsigned HOME     = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_playing,
    input  logic [1:0]    i_speed,
    input  logic [XW-1:0] i_ball_x,
    input  logic          i_ball_toward,
    output logic [XW-1:0] o_pad_x,
    output logic          o_pad_moved,
    output logic          o_pad_dir
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_RETURN = 2'd2;

    localparam logic [XW:0]   C_COLS = (XW+1)'(COLS);
    localparam logic [XW-1:0] C_LAST = XW'(COLS - 1);
    localparam logic [XW-1:0] C_PMIN = XW'(PAD_HALF);
    localparam logic [XW-1:0] C_PMAX = XW'(COLS - 1 - PAD_HALF);
    localparam logic [XW-1:0] C_HOME = XW'(HOME);

    logic [1:0]    r_state;
    logic [1:0]    r_cnt;
    logic [XW-1:0] r_pad_x;
    logic          r_pad_moved;
    logic          r_pad_dir;

    logic [1:0]    w_next_state;
    logic          w_tick;
    logic          w_suppress;
    logic [XW-1:0] w_ball_sat;
    logic [XW-1:0] w_track_tgt;
    logic [XW-1:0] w_target;
    logic          w_move_en;
    logic          w_step_up;
    logic          w_step_dn;

`ifdef PAD_AI_JITTER_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    // Pre-advance value decides suppression for the current tick
    assign w_suppress = (r_lfsr[2:0] == 3'b000);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= 8'hA5;
        end else if (w_tick) begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, tick decode and move decision
    always_comb begin
        w_next_state = S_IDLE;
        w_tick       = 1'b0;
        w_ball_sat   = i_ball_x;
        w_track_tgt  = i_ball_x;
        w_target     = C_HOME;
        w_move_en    = 1'b0;
        w_step_up    = 1'b0;
        w_step_dn    = 1'b0;

        if (!i_playing) begin
            w_next_state = S_IDLE;
        end else if (i_ball_toward) begin
            w_next_state = S_TRACK;
        end else begin
            w_next_state = S_RETURN;
        end

        w_tick = i_playing && (r_cnt >= i_speed);

        if ({1'b0, i_ball_x} >= C_COLS) begin
            w_ball_sat = C_LAST;
        end
        if (w_ball_sat < C_PMIN) begin
            w_track_tgt = C_PMIN;
        end else if (w_ball_sat > C_PMAX) begin
            w_track_tgt = C_PMAX;
        end else begin
            w_track_tgt = w_ball_sat;
        end

        if (r_state == S_TRACK) begin
            w_target = w_track_tgt;
        end

        w_move_en = w_tick && (r_state != S_IDLE) && !w_suppress;
        w_step_up = w_move_en && (r_pad_x < w_target);
        w_step_dn = w_move_en && (r_pad_x > w_target);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 2'd0;
        end else if (!i_playing || w_tick) begin
            r_cnt <= 2'd0;
        end else begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Paddle position; leaving play or sitting idle snaps home without a pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pad_x     <= C_HOME;
            r_pad_moved <= 1'b0;
            r_pad_dir   <= 1'b0;
        end else begin
            r_pad_moved <= 1'b0;
            if (!i_playing || (r_state == S_IDLE)) begin
                r_pad_x <= C_HOME;
            end else if (w_step_up) begin
                r_pad_x     <= r_pad_x + XW'(1);
                r_pad_dir   <= 1'b1;
                r_pad_moved <= 1'b1;
            end else if (w_step_dn) begin
                r_pad_x     <= r_pad_x - XW'(1);
                r_pad_dir   <= 1'b0;
                r_pad_moved <= 1'b1;
            end
        end
    end

    assign o_pad_x     = r_pad_x;
    assign o_pad_moved = r_pad_moved;
    assign o_pad_dir   = r_pad_dir;

endmodule

// File: tb/tb_pad_ai_ctrl.sv
// Bench for pad_ai_ctrl: directed scenarios plus random play against a behavioural model.
module tb_pad_ai_ctrl;

    localparam int COLS     = 8;
    localparam int PAD_HALF = 1;
    localparam int HOME     = 3;
    localparam int PMIN     = PAD_HALF;
    localparam int PMAX     = COLS - 1 - PAD_HALF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       playing = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [2:0] ball_x = 3'd0;
    logic       ball_toward = 1'b0;
    logic [2:0] pad_x;
    logic       pad_moved;
    logic       pad_dir;

    int checks = 0;
    int errors = 0;

    // Reference model: integers and the spec's three modes
    int m_x = HOME, m_dir = 0, m_moved = 0, m_cnt = 0, m_mode = 0, m_lfsr = 8'hA5;
    int n_supp = 0;

    pad_ai_ctrl #(.COLS(COLS), .XW(3), .PAD_HALF(PAD_HALF), .HOME(HOME)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_playing     (playing),
        .i_speed       (speed),
        .i_ball_x      (ball_x),
        .i_ball_toward (ball_toward),
        .o_pad_x       (pad_x),
        .o_pad_moved   (pad_moved),
        .o_pad_dir     (pad_dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_step(input int r, input int pl, input int sp, input int bx, input int tw);
        int tick, supp, tgt, fb;
        if (r != 0) begin
            m_x = HOME; m_dir = 0; m_moved = 0; m_cnt = 0; m_mode = 0; m_lfsr = 8'hA5;
            return;
        end
        tick = (pl != 0 && m_cnt >= sp) ? 1 : 0;
        supp = 0;
`ifdef PAD_AI_JITTER_EN
        if (tick != 0) begin
            supp = (m_lfsr % 8 == 0) ? 1 : 0;
            fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 255;
        end
`else
        fb = 0;
`endif
        m_moved = 0;
        if (pl == 0 || m_mode == 0) begin
            m_x = HOME;
        end else if (tick != 0) begin
            if (supp != 0 && m_mode != 0) n_supp++;
            if (supp == 0) begin
                tgt = (m_mode == 1) ? clampi((bx > COLS - 1) ? COLS - 1 : bx, PMIN, PMAX) : HOME;
                if (m_x < tgt) begin
                    m_x++; m_dir = 1; m_moved = 1;
                end else if (m_x > tgt) begin
                    m_x--; m_dir = 0; m_moved = 1;
                end
            end
        end
        m_cnt  = (pl == 0 || tick != 0) ? 0 : m_cnt + 1;
        m_mode = (pl == 0) ? 0 : ((tw != 0) ? 1 : 2);
    endtask

    // One clock: drive inputs, advance model, sample after the edge, compare
    task automatic cyc(input int r, input int pl, input int sp, input int bx, input int tw);
        rst         = (r != 0);
        playing     = (pl != 0);
        speed       = 2'(sp);
        ball_x      = 3'(bx);
        ball_toward = (tw != 0);
        model_step(r, pl, sp, bx, tw);
        @(posedge clk);
        #1;
        chk("pad_x", int'(pad_x), m_x);
        chk("pad_moved", int'(pad_moved), m_moved);
        chk("pad_dir", int'(pad_dir), m_dir);
    endtask

    initial begin
        // Reset, then idle for 20 cycles
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("rst_pad_x", int'(pad_x), HOME);
        chk("rst_moved", int'(pad_moved), 0);
        chk("rst_dir", int'(pad_dir), 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1));
        chk("idle_home", int'(pad_x), HOME);

        // Track right to PMAX, then left to PMIN
        for (int i = 0; i < 40; i++) cyc(0, 1, 1, 7, 1);
        chk("pmax_stop", int'(pad_x), PMAX);
        for (int i = 0; i < 60; i++) cyc(0, 1, 1, 0, 1);
        chk("pmin_stop", int'(pad_x), PMIN);

        // Speed 0 and speed 3 from home toward column 6
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 6, 1);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 1, 3, 6, 1);

        // Recede: return to home and hold
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 6, 0);
        chk("return_home", int'(pad_x), HOME);
        chk("return_dir", int'(pad_dir), 0);

        // Leave play mid-count from column 5, then reset while playing
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 5, 1);
        cyc(0, 1, 3, 5, 1);
        cyc(0, 0, 3, 5, 1);
        chk("drop_home", int'(pad_x), HOME);
        chk("drop_pulse", int'(pad_moved), 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 6, 1);
        cyc(1, 1, 0, 6, 1);
        chk("rst_play_x", int'(pad_x), HOME);

        // Alternating far targets at full speed; exercises jitter suppression when built in
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) cyc(0, 1, 0, ((i / 8) % 2 == 0) ? 6 : 1, 1);

        // Random play
        for (int i = 0; i < 2500; i++) begin
            cyc(($urandom_range(0, 199) == 0) ? 1 : 0,
                ($urandom_range(0, 19) == 0) ? 0 : 1,
                $urandom_range(0, 3), $urandom_range(0, 7),
                ($urandom_range(0, 9) < 6) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
